// File: rtl/systolic_output_collector.sv
// Drain-side collector for the systolic array: de-skews the per-column out_sum
// stream into whole rows, buffers them in a small FIFO and hands them out over valid/ready.
module systolic_output_collector #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] out_sum [MATRIX_SIZE-1:0],
  input  logic                 in_valid,
  output logic [DATA_SIZE-1:0] res_data [MATRIX_SIZE-1:0],
  output logic                 res_valid,
  output logic                 res_last,
  input  logic                 res_ready,
  output logic                 overflow
);

  localparam int N  = MATRIX_SIZE;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef logic [N-1:0][DATA_SIZE-1:0] row_t;

  logic w_al_valid;
  row_t w_al_row;

  // in_valid marks column 0; delaying it N-1 cycles lines it up with the last column.
  generate
    if (N == 1) begin : g_vskew_none
      assign w_al_valid = in_valid;
    end else begin : g_vskew
      logic r_vskew [N-1];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < N - 1; k++) r_vskew[k] <= 1'b0;
        end else begin
          r_vskew[0] <= in_valid;
          for (int k = 1; k < N - 1; k++) r_vskew[k] <= r_vskew[k-1];
        end
      end
      assign w_al_valid = r_vskew[N-2];
    end
  endgenerate

  generate
    for (genvar j = 0; j < N; j++) begin : g_col
      localparam int DLY = N - 1 - j;
      if (DLY == 0) begin : g_wire
        assign w_al_row[j] = out_sum[j];
      end else begin : g_dly
        logic [DATA_SIZE-1:0] r_dly [DLY];
        // NOTE: data-only pipelines carry no reset; the valid path alone decides what gets stored.
        always_ff @(posedge clk) begin
          r_dly[0] <= out_sum[j];
          for (int k = 1; k < DLY; k++) r_dly[k] <= r_dly[k-1];
        end
        assign w_al_row[j] = r_dly[DLY-1];
      end
    end
  endgenerate

  logic [CW-1:0] r_row_cnt;
  logic          w_row_last;

  assign w_row_last = (r_row_cnt == CW'(N - 1));

  // The counter tracks the row index of every aligned row, dropped ones included.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_cnt <= '0;
    end else if (w_al_valid) begin
      r_row_cnt <= w_row_last ? '0 : r_row_cnt + CW'(1);
    end
  end

  row_t              r_mem      [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_last;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW:0]       r_count;
  logic              r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_count == (PW+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && res_ready;
  assign w_push  = w_al_valid && (!w_full || w_pop);
  assign w_drop  = w_al_valid && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]      <= w_al_row;
      r_mem_last[r_wr_ptr] <= w_row_last;
    end
  end

  // Stale storage is masked while empty so the consumer sees clean zeros.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      res_data[j] = w_empty ? '0 : r_mem[r_rd_ptr][j];
    end
  end

  assign res_valid = !w_empty;
  assign res_last  = !w_empty && r_mem_last[r_rd_ptr];
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_systolic_output_collector.sv
// Bench for systolic_output_collector: N=2 vector table and corner sequences,
// plus an N=4 randomized sweep against a FIFO scoreboard model.
module tb_systolic_output_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] os2 [1:0];
  logic [31:0] rd2 [1:0];
  logic        iv2, rdy2, rv2, rl2, ov2;
  logic [31:0] os4 [3:0];
  logic [31:0] rd4 [3:0];
  logic        iv4, rdy4, rv4, rl4, ov4;

  systolic_output_collector #(.MATRIX_SIZE(2), .DATA_SIZE(32), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .reset(reset), .out_sum(os2), .in_valid(iv2),
    .res_data(rd2), .res_valid(rv2), .res_last(rl2), .res_ready(rdy2), .overflow(ov2)
  );

  systolic_output_collector #(.MATRIX_SIZE(4), .DATA_SIZE(32), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .out_sum(os4), .in_valid(iv4),
    .res_data(rd4), .res_valid(rv4), .res_last(rl4), .res_ready(rdy4), .overflow(ov4)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check2(input string tag, input logic ev, input logic [31:0] e0,
                        input logic [31:0] e1, input logic el, input logic eov);
    check({tag, "_valid"}, 128'(rv2), 128'(ev));
    check({tag, "_data"}, 128'({rd2[1], rd2[0]}), 128'({e1, e0}));
    check({tag, "_last"}, 128'(rl2), 128'(el));
    check({tag, "_ovf"}, 128'(ov2), 128'(eov));
  endtask

  task automatic drive2(input logic iv, input logic [31:0] s0, input logic [31:0] s1,
                        input logic rdy);
    iv2 = iv; os2[0] = s0; os2[1] = s1; rdy2 = rdy;
  endtask

  task automatic idle4();
    iv4 = 1'b0; rdy4 = 1'b0;
    for (int j = 0; j < 4; j++) os4[j] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive2(1'b0, 32'd0, 32'd0, 1'b0);
    idle4();
    @(negedge clk);
    check2("reset", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("reset_n4_valid", 128'(rv4), 128'd0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] s0, s1;
    logic        rdy;
    logic        ev;
    logic [31:0] e0, e1;
    logic        el, eov;
  } vec_t;

  typedef struct packed {
    logic [127:0] d;
    logic         last;
  } exp_t;

  vec_t         tv [5];
  exp_t         q [$];
  logic [127:0] rows [0:511];
  bit           iss  [0:511];

  initial begin
    int  rc;
    bit  mov, pop, al, full, rdy;

    reset = 1'b1;
    drive2(1'b0, 32'd0, 32'd0, 1'b0);
    idle4();

    // Single matrix through a ready consumer.
    tv[0] = '{1'b1, 32'd5,  32'd99, 1'b1, 1'b0, 32'd0,  32'd0,  1'b0, 1'b0};
    tv[1] = '{1'b1, 32'd11, 32'd7,  1'b1, 1'b0, 32'd0,  32'd0,  1'b0, 1'b0};
    tv[2] = '{1'b0, 32'd0,  32'd13, 1'b1, 1'b1, 32'd5,  32'd7,  1'b0, 1'b0};
    tv[3] = '{1'b0, 32'd0,  32'd0,  1'b1, 1'b1, 32'd11, 32'd13, 1'b1, 1'b0};
    tv[4] = '{1'b0, 32'd0,  32'd0,  1'b1, 1'b0, 32'd0,  32'd0,  1'b0, 1'b0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check2($sformatf("vec%0d", k), tv[k].ev, tv[k].e0, tv[k].e1, tv[k].el, tv[k].eov);
      drive2(tv[k].iv, tv[k].s0, tv[k].s1, tv[k].rdy);
    end

    // Backpressure: six rows into a four-deep FIFO, rows 5 and 6 dropped.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      drive2(k < 6, (k < 6) ? 32'(2 * k + 1) : 32'd0, (k >= 1) ? 32'(2 * k) : 32'd0, 1'b0);
    end
    @(negedge clk);
    check2("bp_full", 1'b1, 32'd1, 32'd2, 1'b0, 1'b1);
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      check2($sformatf("bp_drain%0d", m), 1'b1, 32'(2 * m + 1), 32'(2 * m + 2), m % 2 == 1, 1'b1);
      drive2(1'b0, 32'd0, 32'd0, 1'b1);
    end
    @(negedge clk);
    check2("bp_empty", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    drive2(1'b1, 32'd21, 32'd0, 1'b1);
    @(negedge clk);
    check2("cont_wait", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    drive2(1'b0, 32'd0, 32'd22, 1'b1);
    @(negedge clk);
    check2("cont_row", 1'b1, 32'd21, 32'd22, 1'b0, 1'b1);
    drive2(1'b0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    check2("cont_empty", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

    // Reset one cycle after in_valid, with a row queued and one in the skew line.
    drive2(1'b1, 32'd61, 32'd0, 1'b0);
    @(negedge clk);
    drive2(1'b1, 32'd63, 32'd62, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    drive2(1'b1, 32'd99, 32'd64, 1'b0);
    @(negedge clk);
    check2("rst_mid", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    reset = 1'b0;
    drive2(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check2("rst_idle", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive2(1'b1, 32'd3, 32'd0, 1'b0);
    @(negedge clk);
    check2("rst_wait", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive2(1'b0, 32'd0, 32'd4, 1'b1);
    @(negedge clk);
    check2("rst_fresh", 1'b1, 32'd3, 32'd4, 1'b0, 1'b0);
    drive2(1'b0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    check2("rst_after", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Full FIFO with a pop on the cycle the fifth row aligns.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive2(k < 5, (k < 5) ? 32'(40 + 2 * k) : 32'd0, (k >= 1) ? 32'(41 + 2 * (k - 1)) : 32'd0,
             k == 5);
    end
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      check2($sformatf("fp_drain%0d", m), 1'b1, 32'(42 + 2 * m), 32'(43 + 2 * m), m % 2 == 0, 1'b0);
      drive2(1'b0, 32'd0, 32'd0, 1'b1);
    end
    @(negedge clk);
    check2("fp_empty", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    // N=4 sweep: skewed random rows, random ready with a forced stall window.
    do_reset();
    rc  = 0;
    mov = 1'b0;
    for (int c = 0; c < 440; c++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        check("n4_valid", 128'(rv4), 128'd0);
        check("n4_data", {rd4[3], rd4[2], rd4[1], rd4[0]}, 128'd0);
        check("n4_last", 128'(rl4), 128'd0);
      end else begin
        check("n4_valid", 128'(rv4), 128'd1);
        check("n4_data", {rd4[3], rd4[2], rd4[1], rd4[0]}, q[0].d);
        check("n4_last", 128'(rl4), 128'(q[0].last));
      end
      check("n4_ovf", 128'(ov4), 128'(mov));

      iss[c]  = (c < 400) && ($urandom_range(0, 9) < 7);
      rows[c] = {$urandom, $urandom, $urandom, $urandom};
      rdy     = (c >= 400) || (!(c >= 100 && c < 130) && ($urandom_range(0, 3) != 0));
      for (int j = 0; j < 4; j++) begin
        if (c >= j && iss[c - j]) os4[j] = rows[c - j][32 * j +: 32];
        else                      os4[j] = $urandom;
      end
      iv4  = iss[c];
      rdy4 = rdy;

      pop  = (q.size() > 0) && rdy;
      al   = (c >= 3) && iss[c - 3];
      full = (q.size() == 4);
      if (pop) void'(q.pop_front());
      if (al) begin
        if (!full || pop) q.push_back('{d: rows[c - 3], last: (rc == 3)});
        else              mov = 1'b1;
        rc = (rc + 1) % 4;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/systolic_output_collector.md
# systolic_output_collector

Drain-side companion to the systolic array. Captures the column-skewed `out_sum` stream leaving the bottom row of PEs, where column j of a result row emerges j cycles after column 0. Delays each column so every row is realigned into one word, buffers the aligned rows in a small FIFO, and presents them downstream over a valid/ready handshake with a per-matrix `res_last` tag. Sits between the array's `out_sum` outputs and the result consumer; the scheduler drives `in_valid`.

## Interface
- `MATRIX_SIZE`, default 2, array dimension N (N ≥ 1); number of columns and rows per matrix.
- `DATA_SIZE`, default 32, width of each column sum.
- `FIFO_DEPTH`, default 4, aligned-row buffer entries (power of two, ≥ 2).

- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high.
- `out_sum`  input  DATA_SIZE × [MATRIX_SIZE-1:0] unpacked  skewed column sums from the array.
- `in_valid`  input  1  scheduler pulse: the column-0 value for a result row is on `out_sum[0]` this cycle.
- `res_data`  output  DATA_SIZE × [MATRIX_SIZE-1:0] unpacked  aligned row at FIFO head; `res_data[j]` is column j.
- `res_valid`  output  1  FIFO non-empty.
- `res_last`  output  1  head row is row N-1 of its matrix.
- `res_ready`  input  1  consumer accepts head row when high with `res_valid`.
- `overflow`  output  1  sticky: an aligned row arrived while the FIFO was full and was dropped.

## Operation
- Valid skew line: N-1 registers carrying `in_valid`; tap `al_valid` = `in_valid` delayed N-1 cycles (combinational passthrough when N=1).
- Column j delay line: N-1-j registers; column N-1 is a direct wire. At `al_valid`, the taps hold column j of the row whose `in_valid` was j cycles before the column-j sample, i.e. one complete row.
- Row counter: 0..N-1, increments on every `al_valid` (accepted or dropped), wraps N-1 → 0. Entry written with `last` = (counter == N-1).
- FIFO write: on `al_valid` if not full, or if full and a pop occurs in the same cycle (pop-then-push; occupancy unchanged).
- FIFO pop: `res_valid && res_ready`.
- Drop: `al_valid` while full and no pop → row discarded, `overflow` set, counter still advances.
- `overflow` clears only on `reset`.
- Empty: `res_valid`=0, `res_data` all 0, `res_last`=0.
- `res_ready` high while empty: no effect.
- Back-to-back `in_valid` every cycle is supported; throughput one row per cycle with `res_ready` held high.
- Pointers wrap modulo FIFO_DEPTH; full/empty distinguished by an occupancy counter of width clog2(FIFO_DEPTH)+1.
- No arithmetic on data; sums pass through bit-exact.

## Timing
- `in_valid` at cycle t → `al_valid` at t+N-1 → FIFO write at end of t+N-1 → `res_valid` earliest at cycle t+N (N=2: t+2).
- Column j data for that row must be on `out_sum[j]` at cycle t+j.
- Pop takes effect at the clock edge; next entry visible the following cycle.
- Reset (synchronous, any cycle, including mid-row): clears skew/delay valid bits, row counter, pointers, occupancy, `overflow`. Cycle after reset: `res_valid`=0, `res_data`=0, `res_last`=0, `overflow`=0. Rows partly in the skew lines at reset are lost; no partial row is ever emitted.
- `in_valid` sampled during reset is ignored.

## Test plan
- Single matrix, N=2, `res_ready`=1: `in_valid` at t and t+1; `out_sum[0]`=5@t, 11@t+1; `out_sum[1]`=7@t+1, 13@t+2 → `res_data`={5,7} `res_last`=0 at t+2, {11,13} `res_last`=1 at t+3, `res_valid` low at t+4.
- Backpressure, N=2, depth 4: `res_ready`=0, six rows back-to-back (values 1..12) → four rows held, rows 5-6 dropped, `overflow`=1; then `res_ready`=1 drains rows 1-4 in order, `res_last` on rows 2 and 4.
- Full with simultaneous pop: FIFO full, `res_ready`=1 on the cycle a new aligned row arrives → row accepted, no overflow, occupancy stays 4.
- Counter continuity across drop: drop row index 1 (last) of a matrix → next accepted row tagged `res_last`=0 (index 0 of next matrix).
- Reset mid-operation: assert `reset` one cycle after `in_valid` with rows queued → next cycle all outputs 0; later fresh row {3,4} emerges with `res_last`=0 at nominal latency.
- N=4 sweep: random rows with correct skew, random `res_ready` → scoreboard matches every accepted row bit-exact, `res_last` every 4th row.
